// File: rtl/iohub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iohub_pkg
// Description : Shared register map, bit positions and TX state encoding
//               for the IO hub UART bridge.
// Revision    : 1.0
// ============================================================================
package iohub_pkg;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_RXDATA = 2'd2;
    localparam logic [1:0] REG_TXDATA = 2'd3;

    localparam int STAT_RX_EMPTY = 0;
    localparam int STAT_RX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_TX_FULL  = 3;
    localparam int STAT_RX_OVF   = 4;
    localparam int STAT_TX_OVF   = 5;
    localparam int STAT_TX_BUSY  = 6;
    localparam int STAT_RX_COUNT = 7;

    localparam int CTRL_ENABLE    = 0;
    localparam int CTRL_LOOPBACK  = 1;
    localparam int CTRL_RX_IRQ_EN = 2;
    localparam int CTRL_CLR_OVF   = 3;
    localparam int CTRL_FLUSH     = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SEND   = 3'd2,
        WSTART = 3'd3,
        WDONE  = 3'd4,
        NEXT   = 3'd5
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/iohub_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : iohub_sync_fifo
// Description : Synchronous first-word-fall-through FIFO with flush.
// Revision    : 1.0
// ============================================================================
module iohub_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A push into a full FIFO still lands when a pop frees the slot this cycle.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/iohub_uart_bridge.sv
`default_nettype none
// ============================================================================
// Module      : iohub_uart_bridge
// Description : Packs UART bytes into bus words and back, with per-direction
//               FIFOs and a small CSR block on the io_* slave bus.
// Revision    : 1.0
// ============================================================================
module iohub_uart_bridge
    import iohub_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              io_stb_i,
    input  logic              io_we_i,
    input  logic [ADDR_W-1:0] io_addr_i,
    input  logic [DATA_W-1:0] io_dat_i,
    output logic [DATA_W-1:0] io_dat_o,
    output logic              io_ack_o,
    output logic              irq_o,
    input  logic [7:0]        rx_byte_i,
    input  logic              received_i,
    input  logic              is_transmitting_i,
    output logic [7:0]        tx_byte_o,
    output logic              transmit_o
);
    localparam int NB     = DATA_W / 8;
    localparam int SEL    = $clog2(NB);
    localparam int BC_W   = (NB > 1) ? $clog2(NB) : 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int STAT_W = (DATA_W > STAT_RX_COUNT + CNT_W) ? DATA_W : STAT_RX_COUNT + CNT_W;
    localparam logic [BC_W-1:0] C_LAST_BYTE = BC_W'(NB - 1);

    logic              r_ack;
    logic [DATA_W-1:0] r_dat;
    logic              r_irq;
    logic              r_enable;
    logic              r_loopback;
    logic              r_irq_en;
    logic              r_rx_ovf;
    logic              r_tx_ovf;
    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [BC_W-1:0]   r_tx_idx;
    logic [DATA_W-1:0] r_asm;
    logic [BC_W-1:0]   r_rx_bc;

    logic [1:0]        w_sel;
    logic              w_accept;
    logic              w_ctrl_wr;
    logic              w_flush;
    logic              w_clr_ovf;
    logic              w_rx_pop;
    logic              w_tx_push;
    logic              w_tx_pop;
    logic              w_transmit;
    logic              w_byte_vld;
    logic [7:0]        w_byte;
    logic [DATA_W-1:0] w_rx_word;
    logic              w_rx_push;
    logic              w_rx_ovf_set;
    logic              w_tx_ovf_set;
    logic [DATA_W-1:0] w_rx_dout;
    logic [DATA_W-1:0] w_tx_dout;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic [CNT_W-1:0]  w_rx_count;
    logic [CNT_W-1:0]  w_tx_count;
    logic [STAT_W-1:0] w_stat_ext;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_unused;

    assign w_unused = ^{io_addr_i, w_tx_count};

    // Bus decode; every side effect is tied to the acceptance edge.
    assign w_sel     = io_addr_i[SEL+1:SEL];
    assign w_accept  = io_stb_i & ~r_ack;
    assign w_ctrl_wr = w_accept & io_we_i & (w_sel == REG_CTRL);
    assign w_flush   = w_ctrl_wr & io_dat_i[CTRL_FLUSH];
    assign w_clr_ovf = w_ctrl_wr & io_dat_i[CTRL_CLR_OVF];
    assign w_rx_pop  = w_accept & ~io_we_i & (w_sel == REG_RXDATA);
    assign w_tx_push = w_accept & io_we_i & (w_sel == REG_TXDATA);

    iohub_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (w_rx_push),
        .pop   (w_rx_pop),
        .flush (w_flush),
        .din   (w_rx_word),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    iohub_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (w_tx_push),
        .pop   (w_tx_pop),
        .flush (w_flush),
        .din   (io_dat_i),
        .dout  (w_tx_dout),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    // Overflow only counts a word that is really lost, not one rescued by a
    // same-cycle pop or swallowed by a flush.
    assign w_rx_ovf_set = w_rx_push & w_rx_full & ~(w_rx_pop & ~w_rx_empty) & ~w_flush;
    assign w_tx_ovf_set = w_tx_push & w_tx_full & ~(w_tx_pop & ~w_tx_empty) & ~w_flush;

    // RX assembler: loopback taps the byte the TX side is presenting in SEND.
    assign w_byte     = r_loopback ? r_shift[7:0] : rx_byte_i;
    assign w_byte_vld = r_enable & (r_loopback ? (r_state == SEND) : received_i);
    assign w_rx_push  = w_byte_vld & (r_rx_bc == C_LAST_BYTE);

    always_comb begin
        w_rx_word = r_asm;
        w_rx_word[8*int'(r_rx_bc) +: 8] = w_byte;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_asm   <= '0;
            r_rx_bc <= '0;
        end else if (w_flush || !r_enable) begin
            r_rx_bc <= '0;
        end else if (w_byte_vld) begin
            r_asm   <= w_rx_word;
            r_rx_bc <= (r_rx_bc == C_LAST_BYTE) ? '0 : r_rx_bc + 1'b1;
        end
    end

    // TX FSM
    always_comb begin
        w_state_nxt = r_state;
        w_tx_pop    = 1'b0;
        w_transmit  = 1'b0;
        case (r_state)
            IDLE:    if (r_enable && !w_tx_empty) w_state_nxt = LOAD;
            LOAD: begin
                w_tx_pop    = 1'b1;
                w_state_nxt = SEND;
            end
            SEND: begin
                if (r_loopback) begin
                    w_state_nxt = NEXT;
                end else begin
                    w_transmit  = 1'b1;
                    w_state_nxt = WSTART;
                end
            end
            WSTART:  if (is_transmitting_i) w_state_nxt = WDONE;
            WDONE:   if (!is_transmitting_i) w_state_nxt = NEXT;
            NEXT:    w_state_nxt = (r_tx_idx == C_LAST_BYTE) ? IDLE : SEND;
            default: w_state_nxt = IDLE;
        endcase
        if (w_flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_tx_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == LOAD) begin
                r_shift  <= w_tx_dout;
                r_tx_idx <= '0;
            end else if (r_state == NEXT && r_tx_idx != C_LAST_BYTE) begin
                r_shift  <= r_shift >> 8;
                r_tx_idx <= r_tx_idx + 1'b1;
            end
        end
    end

    assign transmit_o = w_transmit;
    assign tx_byte_o  = r_shift[7:0];

    // Register read mux
    always_comb begin
        w_stat_ext                = '0;
        w_stat_ext[STAT_RX_EMPTY] = w_rx_empty;
        w_stat_ext[STAT_RX_FULL]  = w_rx_full;
        w_stat_ext[STAT_TX_EMPTY] = w_tx_empty;
        w_stat_ext[STAT_TX_FULL]  = w_tx_full;
        w_stat_ext[STAT_RX_OVF]   = r_rx_ovf;
        w_stat_ext[STAT_TX_OVF]   = r_tx_ovf;
        w_stat_ext[STAT_TX_BUSY]  = (r_state != IDLE);
        w_stat_ext[STAT_RX_COUNT +: CNT_W] = w_rx_count;
    end

    always_comb begin
        w_rd_data = '0;
        case (w_sel)
            REG_STATUS: w_rd_data = w_stat_ext[DATA_W-1:0];
            REG_CTRL: begin
                w_rd_data[CTRL_ENABLE]    = r_enable;
                w_rd_data[CTRL_LOOPBACK]  = r_loopback;
                w_rd_data[CTRL_RX_IRQ_EN] = r_irq_en;
            end
            REG_RXDATA: w_rd_data = w_rx_empty ? '0 : w_rx_dout;
            default:    w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_irq      <= 1'b0;
            r_enable   <= 1'b0;
            r_loopback <= 1'b0;
            r_irq_en   <= 1'b0;
            r_rx_ovf   <= 1'b0;
            r_tx_ovf   <= 1'b0;
        end else begin
            r_ack <= w_accept;
            if (w_accept) r_dat <= io_we_i ? '0 : w_rd_data;
            if (w_ctrl_wr) begin
                r_enable   <= io_dat_i[CTRL_ENABLE];
                r_loopback <= io_dat_i[CTRL_LOOPBACK];
                r_irq_en   <= io_dat_i[CTRL_RX_IRQ_EN];
            end
            r_rx_ovf <= w_rx_ovf_set | (r_rx_ovf & ~w_clr_ovf);
            r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~w_clr_ovf);
            r_irq    <= r_irq_en & ~w_rx_empty;
        end
    end

    assign io_ack_o = r_ack;
    assign io_dat_o = r_dat;
    assign irq_o    = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_iohub_uart_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_iohub_uart_bridge
// Description : Scoreboard bench for iohub_uart_bridge with a simple uart model.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_iohub_uart_bridge;
    import iohub_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 16;
    localparam int SEL    = $clog2(DATA_W/8);

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              io_stb_i;
    logic              io_we_i;
    logic [ADDR_W-1:0] io_addr_i;
    logic [DATA_W-1:0] io_dat_i;
    logic [DATA_W-1:0] io_dat_o;
    logic              io_ack_o;
    logic              irq_o;
    logic [7:0]        rx_byte_i;
    logic              received_i;
    logic              is_transmitting_i;
    logic [7:0]        tx_byte_o;
    logic              transmit_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_tx_pulses = 0;
    logic [DATA_W-1:0] rx_q[$];
    logic [8:0]        tx_q[$];

    iohub_uart_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .io_stb_i          (io_stb_i),
        .io_we_i           (io_we_i),
        .io_addr_i         (io_addr_i),
        .io_dat_i          (io_dat_i),
        .io_dat_o          (io_dat_o),
        .io_ack_o          (io_ack_o),
        .irq_o             (irq_o),
        .rx_byte_i         (rx_byte_i),
        .received_i        (received_i),
        .is_transmitting_i (is_transmitting_i),
        .tx_byte_o         (tx_byte_o),
        .transmit_o        (transmit_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_xfer(input logic we, input logic [1:0] idx, input logic [DATA_W-1:0] wd,
                            output logic [DATA_W-1:0] rd);
        int n;
        n = 0;
        io_stb_i  = 1'b1;
        io_we_i   = we;
        io_addr_i = ADDR_W'(idx) << SEL;
        io_dat_i  = wd;
        do begin
            @(posedge clk_i); #1;
            n++;
        end while (!io_ack_o && n < 8);
        if (!io_ack_o) check_val("bus_ack_timeout", {63'd0, io_ack_o}, 64'd1);
        rd       = io_dat_o;
        io_stb_i = 1'b0;
        io_we_i  = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic bus_wr(input logic [1:0] idx, input logic [DATA_W-1:0] wd);
        logic [DATA_W-1:0] dummy;
        bus_xfer(1'b1, idx, wd, dummy);
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_byte_i  = b;
        received_i = 1'b1;
        @(posedge clk_i); #1;
        received_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    // Uart model: busy for 10 cycles after every start strobe; bytes checked in order.
    initial begin
        logic [8:0] exp_b;
        is_transmitting_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (transmit_o === 1'b1) begin
                n_tx_pulses++;
                exp_b = (tx_q.size() > 0) ? tx_q.pop_front() : 9'h100;
                check_val("tx_byte", {56'd0, tx_byte_o}, {55'd0, exp_b});
                is_transmitting_i = 1'b1;
                repeat (10) @(posedge clk_i);
                #1 is_transmitting_i = 1'b0;
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] rd;
        int n;
        int p0;

        rst_i      = 1'b1;
        io_stb_i   = 1'b0;
        io_we_i    = 1'b0;
        io_addr_i  = '0;
        io_dat_i   = '0;
        rx_byte_i  = '0;
        received_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Reset state
        check_val("rst_outputs", {io_ack_o, irq_o, transmit_o, tx_byte_o, io_dat_o}, 64'd0);
        bus_xfer(1'b0, REG_STATUS, '0, rd);
        check_val("rst_status", rd, 64'h0005);

        // RX packing, LSB first
        bus_wr(REG_CTRL, 16'h0001);
        rx_q.push_back(16'h1234);
        rx_send(8'h34);
        rx_send(8'h12);
        bus_xfer(1'b0, REG_STATUS, '0, rd);
        check_val("rx_status_one", rd, 64'h0084);
        bus_xfer(1'b0, REG_RXDATA, '0, rd);
        check_val("rx_word", rd, rx_q.pop_front());
        bus_xfer(1'b0, REG_RXDATA, '0, rd);
        check_val("rx_read_empty", rd, 64'h0);
        bus_xfer(1'b0, REG_STATUS, '0, rd);
        check_val("rx_status_empty", rd, 64'h0005);

        // TX unpacking through the uart model
        p0 = n_tx_pulses;
        tx_q.push_back(9'h0EF);
        tx_q.push_back(9'h0BE);
        bus_wr(REG_TXDATA, 16'hBEEF);
        bus_xfer(1'b0, REG_STATUS, '0, rd);
        check_val("tx_status_busy", rd, 64'h0041);
        n = 0;
        do begin
            bus_xfer(1'b0, REG_STATUS, '0, rd);
            n++;
        end while (rd[STAT_TX_BUSY] && n < 40);
        check_val("tx_status_done", rd, 64'h0005);
        check_val("tx_pulses", 64'(n_tx_pulses - p0), 64'd2);
        check_val("tx_q_drained", 64'(tx_q.size()), 64'd0);

        // TX overflow with enable off, then clr_ovf
        bus_wr(REG_CTRL, 16'h0000);
        for (int i = 0; i <= DEPTH; i++) bus_wr(REG_TXDATA, 16'(i));
        bus_xfer(1'b0, REG_STATUS, '0, rd);
        check_val("tx_ovf_status", rd, 64'h0029);
        bus_wr(REG_CTRL, 16'h0008);
        bus_xfer(1'b0, REG_STATUS, '0, rd);
        check_val("tx_clr_ovf", rd, 64'h0009);
        bus_xfer(1'b0, REG_CTRL, '0, rd);
        check_val("ctrl_selfclear", rd, 64'h0000);
        bus_wr(REG_CTRL, 16'h0010);
        bus_xfer(1'b0, REG_STATUS, '0, rd);
        check_val("tx_flush_status", rd, 64'h0005);

        // Loopback with RX interrupt
        p0 = n_tx_pulses;
        bus_wr(REG_CTRL, 16'h0007);
        bus_xfer(1'b0, REG_CTRL, '0, rd);
        check_val("ctrl_readback", rd, 64'h0007);
        rx_q.push_back(16'hA55A);
        bus_wr(REG_TXDATA, 16'hA55A);
        n = 0;
        while (!irq_o && n < 30) begin
            @(posedge clk_i); #1;
            n++;
        end
        check_val("lb_irq_rise", {63'd0, irq_o}, 64'd1);
        bus_xfer(1'b0, REG_RXDATA, '0, rd);
        check_val("lb_word", rd, rx_q.pop_front());
        repeat (3) @(posedge clk_i);
        #1 check_val("lb_irq_fall", {63'd0, irq_o}, 64'd0);
        check_val("lb_no_transmit", 64'(n_tx_pulses - p0), 64'd0);

        // RX overflow, then flush with a pending TX word
        bus_wr(REG_CTRL, 16'h0001);
        for (int i = 0; i < 2*DEPTH + 2; i += 2) begin
            if (i < 2*DEPTH) rx_q.push_back({8'(8'h11 + i), 8'(8'h10 + i)});
            rx_send(8'(8'h10 + i));
            rx_send(8'(8'h11 + i));
        end
        bus_xfer(1'b0, REG_STATUS, '0, rd);
        check_val("rx_ovf_status", rd, 64'h0816);
        bus_xfer(1'b0, REG_RXDATA, '0, rd);
        check_val("rx_ovf_head", rd, rx_q.pop_front());
        bus_xfer(1'b0, REG_STATUS, '0, rd);
        check_val("rx_ovf_count15", rd, 64'h0794);
        p0 = n_tx_pulses;
        bus_wr(REG_CTRL, 16'h0000);
        bus_wr(REG_TXDATA, 16'h7777);
        bus_wr(REG_CTRL, 16'h0011);
        rx_q.delete();
        bus_xfer(1'b0, REG_STATUS, '0, rd);
        check_val("flush_status", rd, 64'h0015);
        repeat (10) @(posedge clk_i);
        #1 check_val("flush_tx_dropped", 64'(n_tx_pulses - p0), 64'd0);
        bus_wr(REG_CTRL, 16'h0009);
        bus_xfer(1'b0, REG_STATUS, '0, rd);
        check_val("rx_clr_ovf", rd, 64'h0005);

        // Asynchronous reset mid-word drops the partial byte
        rx_send(8'hAA);
        #2 rst_i = 1'b1;
        #3 rst_i = 1'b0;
        @(posedge clk_i); #1;
        bus_xfer(1'b0, REG_CTRL, '0, rd);
        check_val("arst_ctrl", rd, 64'h0000);
        bus_wr(REG_CTRL, 16'h0001);
        rx_q.push_back(16'h5678);
        rx_send(8'h78);
        rx_send(8'h56);
        bus_xfer(1'b0, REG_RXDATA, '0, rd);
        check_val("arst_rx_word", rd, rx_q.pop_front());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
